up_down_count_checker: RTL and testbench

//  Receiving-end monitor for the 8-bit up/down loadable counter: samples the counter's

---
 rtl/up_down_cnt_pkg.sv | 22 ++
 rtl/up_down_ref_model.sv | 45 ++++
 rtl/up_down_count_checker.sv | 153 +++++++++++++++
 tb/tb_up_down_count_checker.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/up_down_cnt_pkg.sv
// ---------------------------------------------------------------------------
// up_down_cnt_pkg
// Shared types and constants for the up/down counter checker.
//   chk_state_e : checker FSM states (WAIT_LOAD, TRACK, FAULT)
//   MODE_DOWN / MODE_UP : encoding of the counter direction input
//   DEF_WIDTH / DEF_ECW : default count width and error-counter width
// ---------------------------------------------------------------------------
package up_down_cnt_pkg;

    typedef enum logic [1:0] {
        WAIT_LOAD = 2'd0,
        TRACK     = 2'd1,
        FAULT     = 2'd2
    } chk_state_e;

    localparam logic MODE_DOWN = 1'b0;
    localparam logic MODE_UP   = 1'b1;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_ECW   = 8;

endpackage : up_down_cnt_pkg

// File: rtl/up_down_ref_model.sv
// ---------------------------------------------------------------------------
// up_down_ref_model
// Combinational reference for one step of the loadable up/down counter.
// Ports:
//   expected  in  WIDTH  current model value
//   d_in      in  WIDTH  load data
//   load      in  1      load strobe (priority over mode)
//   mode      in  1      direction, MODE_UP / MODE_DOWN
//   next      out WIDTH  model value after this clock, mod 2^WIDTH
//   wrap_up   out 1      this step goes all-ones -> 0 while counting up
//   wrap_down out 1      this step goes 0 -> all-ones while counting down
// ---------------------------------------------------------------------------
module up_down_ref_model
    import up_down_cnt_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] expected,
    input  logic [WIDTH-1:0] d_in,
    input  logic             load,
    input  logic             mode,
    output logic [WIDTH-1:0] next,
    output logic             wrap_up,
    output logic             wrap_down
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        next      = expected;
        wrap_up   = 1'b0;
        wrap_down = 1'b0;
        if (load) begin
            // A load step never counts as a wrap.
            next = d_in;
        end else if (mode == MODE_UP) begin
            next    = expected + ONE;
            wrap_up = (expected == {WIDTH{1'b1}});
        end else begin
            next      = expected - ONE;
            wrap_down = (expected == {WIDTH{1'b0}});
        end
    end

endmodule : up_down_ref_model

// File: rtl/up_down_count_checker.sv
// ---------------------------------------------------------------------------
// up_down_count_checker
// Monitors an 8-bit (WIDTH) up/down loadable counter: samples its controls
// and output every clock, runs a cycle-accurate model and flags divergence.
// Optional build macro:
//   RESYNC_ON_ERROR_EN  on mismatch stay in TRACK and adopt the observed count
//                       (FAULT unreachable); undefined: mismatch goes to FAULT
//                       until the next load.
// Ports:
//   clock       in   1      rising-edge clock
//   clear       in   1      asynchronous active-low reset
//   enable      in   1      1 = check this cycle, 0 = freeze state
//   d_in        in   WIDTH  counter load data
//   load        in   1      counter load strobe
//   mode        in   1      counter direction (0 down, 1 up)
//   count       in   WIDTH  counter output under check
//   expected    out  WIDTH  value count must equal this cycle
//   synced      out  1      checker is in TRACK
//   mismatch    out  1      registered pulse: last compare failed
//   err_sticky  out  1      set on first mismatch, cleared by clear
//   err_count   out  ECW    saturating mismatch count
//   wrap_up     out  1      registered pulse: model wrapped all-ones -> 0
//   wrap_down   out  1      registered pulse: model wrapped 0 -> all-ones
// ---------------------------------------------------------------------------
module up_down_count_checker
    import up_down_cnt_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ECW   = DEF_ECW
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] d_in,
    input  logic             load,
    input  logic             mode,
    input  logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] expected,
    output logic             synced,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [ECW-1:0]   err_count,
    output logic             wrap_up,
    output logic             wrap_down
);

    localparam logic [ECW-1:0] ERR_ONE = {{(ECW-1){1'b0}}, 1'b1};

    chk_state_e       state_q,      state_d;
    logic [WIDTH-1:0] expected_q,   expected_d;
    logic             mismatch_q,   mismatch_d;
    logic             err_sticky_q, err_sticky_d;
    logic [ECW-1:0]   err_count_q,  err_count_d;
    logic             wrap_up_q,    wrap_up_d;
    logic             wrap_down_q,  wrap_down_d;

    logic [WIDTH-1:0] rm_next;
    logic             rm_wrap_up;
    logic             rm_wrap_down;

`ifdef RESYNC_ON_ERROR_EN
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
`endif

    up_down_ref_model #(
        .WIDTH (WIDTH)
    ) u_ref_model (
        .expected  (expected_q),
        .d_in      (d_in),
        .load      (load),
        .mode      (mode),
        .next      (rm_next),
        .wrap_up   (rm_wrap_up),
        .wrap_down (rm_wrap_down)
    );

    always_comb begin
        state_d      = state_q;
        expected_d   = expected_q;
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;
        // Pulses are one cycle wide, so they drop even while frozen.
        mismatch_d   = 1'b0;
        wrap_up_d    = 1'b0;
        wrap_down_d  = 1'b0;

        if (enable) begin
            unique case (state_q)
                WAIT_LOAD, FAULT: begin
                    if (load) begin
                        expected_d = d_in;
                        state_d    = TRACK;
                    end
                end
                TRACK: begin
                    if (count == expected_q) begin
                        expected_d  = rm_next;
                        wrap_up_d   = rm_wrap_up;
                        wrap_down_d = rm_wrap_down;
                    end else begin
                        mismatch_d   = 1'b1;
                        err_sticky_d = 1'b1;
                        if (err_count_q != {ECW{1'b1}}) begin
                            err_count_d = err_count_q + ERR_ONE;
                        end
                        // A simultaneous load re-establishes sync in either build.
                        if (load) begin
                            expected_d = d_in;
                        end else begin
`ifdef RESYNC_ON_ERROR_EN
                            expected_d = (mode == MODE_UP) ? count + ONE : count - ONE;
`else
                            state_d = FAULT;
`endif
                        end
                    end
                end
                default: begin
                    state_d = WAIT_LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q      <= WAIT_LOAD;
            expected_q   <= '0;
            mismatch_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
            wrap_up_q    <= 1'b0;
            wrap_down_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            expected_q   <= expected_d;
            mismatch_q   <= mismatch_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
            wrap_up_q    <= wrap_up_d;
            wrap_down_q  <= wrap_down_d;
        end
    end

    assign expected   = expected_q;
    assign synced     = (state_q == TRACK);
    assign mismatch   = mismatch_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;
    assign wrap_up    = wrap_up_q;
    assign wrap_down  = wrap_down_q;

endmodule : up_down_count_checker

// File: tb/tb_up_down_count_checker.sv
// ---------------------------------------------------------------------------
// tb_up_down_count_checker
// Directed scenarios followed by randomized traffic for up_down_count_checker,
// checked every cycle against a behavioural model held in this module.
// Honours RESYNC_ON_ERROR_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_up_down_count_checker;

    logic       clock;
    logic       clear;
    logic       enable;
    logic [7:0] d_in;
    logic       load;
    logic       mode;
    logic [7:0] count;
    logic [7:0] expected;
    logic       synced;
    logic       mismatch;
    logic       err_sticky;
    logic [7:0] err_count;
    logic       wrap_up;
    logic       wrap_down;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int m_exp;
    bit m_trk;
    bit m_mis, m_wu, m_wd, m_sticky;
    int m_err;
    int wu_seen, wd_seen;

    up_down_count_checker #(.WIDTH(8), .ECW(8)) dut (
        .clock      (clock),
        .clear      (clear),
        .enable     (enable),
        .d_in       (d_in),
        .load       (load),
        .mode       (mode),
        .count      (count),
        .expected   (expected),
        .synced     (synced),
        .mismatch   (mismatch),
        .err_sticky (err_sticky),
        .err_count  (err_count),
        .wrap_up    (wrap_up),
        .wrap_down  (wrap_down)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_exp = 0; m_trk = 0; m_mis = 0; m_wu = 0; m_wd = 0; m_sticky = 0; m_err = 0;
    endtask

    // One clock of the counter/checker rules, evaluated on the driven inputs.
    task automatic model_step();
        m_mis = 0; m_wu = 0; m_wd = 0;
        if (!enable) return;
        if (!m_trk) begin
            if (load) begin
                m_exp = d_in;
                m_trk = 1;
            end
        end else if (int'(count) != m_exp) begin
            m_mis = 1;
            m_sticky = 1;
            if (m_err < 255) m_err++;
            if (load) m_exp = d_in;
            else begin
`ifdef RESYNC_ON_ERROR_EN
                m_exp = mode ? (int'(count) + 1) % 256 : (int'(count) + 255) % 256;
`else
                m_trk = 0;
`endif
            end
        end else if (load) begin
            m_exp = d_in;
        end else if (mode) begin
            m_wu  = (m_exp == 255);
            m_exp = (m_exp + 1) % 256;
        end else begin
            m_wd  = (m_exp == 0);
            m_exp = (m_exp + 255) % 256;
        end
    endtask

    task automatic compare_all();
        check("expected",   expected,   m_exp);
        check("synced",     synced,     m_trk);
        check("mismatch",   mismatch,   m_mis);
        check("err_sticky", err_sticky, m_sticky);
        check("err_count",  err_count,  m_err);
        check("wrap_up",    wrap_up,    m_wu);
        check("wrap_down",  wrap_down,  m_wd);
    endtask

    task automatic cyc(input bit en, input bit ld, input bit md,
                       input logic [7:0] din, input logic [7:0] cnt);
        enable = en; load = ld; mode = md; d_in = din; count = cnt;
        model_step();
        @(posedge clock);
        #1;
        if (wrap_up)   wu_seen++;
        if (wrap_down) wd_seen++;
        $display("cyc en=%0b ld=%0b md=%0b din=%02h cnt=%02h -> exp=%02h sync=%0b mis=%0b err=%02h wu=%0b wd=%0b",
                 en, ld, md, din, cnt, expected, synced, mismatch, err_count, wrap_up, wrap_down);
        compare_all();
    endtask

    // Counter behaves correctly: count follows the model value.
    task automatic follow(input int n, input bit md);
        for (int i = 0; i < n; i++) cyc(1, 0, md, 8'h00, 8'(m_exp));
    endtask

    initial begin
        logic [7:0] held;
        clear = 1'b0; enable = 0; load = 0; mode = 0; d_in = 0; count = 0;
        model_reset();
        wu_seen = 0; wd_seen = 0;
        #12;
        compare_all();                        // reset state
        clear = 1'b1;
        @(posedge clock); #1;

        // 1: load 04, count down to 00
        cyc(1, 1, 0, 8'h04, 8'h00);
        follow(4, 0);
        check("t1_expected_00", expected, 0);
        check("t1_synced", synced, 1);

        // 2: count up to 04, then load ff and wrap up once
        follow(4, 1);
        check("t2_expected_04", expected, 4);
        wu_seen = 0;
        cyc(1, 1, 1, 8'hff, 8'(m_exp));
        follow(3, 1);
        check("t2_wrap_up_once", wu_seen, 1);

        // 3: load 00 counting down, wrap down once to ff
        wd_seen = 0;
        cyc(1, 1, 0, 8'h00, 8'(m_exp));
        follow(1, 0);
        check("t3_expected_ff", expected, 8'hff);
        check("t3_wrap_down_once", wd_seen, 1);

        // 4: expected 03, counter shows 05
        cyc(1, 1, 1, 8'h03, 8'(m_exp));
        cyc(1, 0, 1, 8'h00, 8'h05);
        check("t4_mismatch", mismatch, 1);
        check("t4_err_count", err_count, 1);
        check("t4_err_sticky", err_sticky, 1);
`ifdef RESYNC_ON_ERROR_EN
        check("t4_resync_exp", expected, 8'h06);
        check("t4_synced", synced, 1);
`else
        check("t4_synced", synced, 0);
        cyc(1, 0, 1, 8'h00, 8'h07);
        check("t4_fault_synced", synced, 0);
        check("t4_fault_nomis", mismatch, 0);
`endif
        cyc(1, 1, 0, 8'hfa, 8'(m_exp));
        check("t4_load_fa", expected, 8'hfa);
        follow(1, 0);
        check("t4_track_f9", expected, 8'hf9);

        // 6: freeze with a bad count
        held = expected;
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 8'h00, ~held);
        check("t6_frozen_exp", expected, held);
        check("t6_no_mismatch", mismatch, 0);
        follow(2, 1);

        // 5: 300 mismatches saturate err_count
        for (int i = 0; i < 300; i++) cyc(1, 1, 1, 8'h10, 8'h20);
        check("t5_err_sat", err_count, 8'hff);
        cyc(1, 1, 0, 8'h40, 8'(m_exp));
        follow(3, 0);
        #2;
        clear = 1'b0;
        model_reset();
        #1;
        compare_all();                        // async clear, before any edge
        @(posedge clock); #1;
        compare_all();
        clear = 1'b1;
        cyc(1, 0, 1, 8'h00, 8'h00);          // WAIT_LOAD ignores count
        check("t5_wait_load", synced, 0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            bit en, ld, md;
            logic [7:0] din, cnt;
            en  = ($urandom_range(0, 9) != 0);
            ld  = ($urandom_range(0, 7) == 0);
            md  = 1'($urandom_range(0, 1));
            din = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0)
                cnt = 8'(m_exp) ^ 8'($urandom_range(1, 255));
            else
                cnt = 8'(m_exp);
            // Bias loads toward the wrap points now and then.
            if (ld && $urandom_range(0, 3) == 0) din = md ? 8'hfe : 8'h01;
            cyc(en, ld, md, din, cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_up_down_count_checker
